// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types: word, RAM state and arbiter state
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_request_arbiter_if.sv
// rtl/mem_request_arbiter_if.sv - request-unit/RAM side bundle of the memory request arbiter
interface mem_request_arbiter_if;
    import cpu_types_pkg::*;

    logic      imemREN;
    word_t     imemaddr;
    logic      dmemREN;
    logic      dmemWEN;
    word_t     dmemaddr;
    word_t     dmemstore;
    logic      ihit;
    logic      dhit;
    word_t     imemload;
    word_t     dmemload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      memerr;

    modport arb (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
        output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

    modport tb (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
        input  ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

endinterface

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - wait-state counter with timeout strobe for one RAM transaction
module wait_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear while no transaction is open, otherwise count wait cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The wait cycle that brings the count to TIMEOUT_CYCLES is the one that aborts.
    assign timeout_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_request_arbiter.sv
// rtl/mem_request_arbiter.sv - data-priority fetch/data arbiter onto single-port RAM; MEM_ARB_STATS_EN adds hit/stall counters
module mem_request_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      imemREN,
    input  word_t     imemaddr,
    input  logic      dmemREN,
    input  logic      dmemWEN,
    input  word_t     dmemaddr,
    input  word_t     dmemstore,
    output logic      ihit,
    output logic      dhit,
    output word_t     imemload,
    output word_t     dmemload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
`ifdef MEM_ARB_STATS_EN
    ,
    output word_t     icount,
    output word_t     dcount,
    output word_t     stallcount
`endif
);

    arb_state_t state_q;
    arb_state_t state_d;
    arb_state_t state_raw;
    logic       memerr_q;
    logic       memerr_d;
    logic       dreq;
    logic       wait_cyc;
    logic       timeout;

    assign dreq = dmemREN | dmemWEN;

    wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wait_timer (
        .CLK      (CLK),
        .nRST     (nRST),
        .clr_i    (state_q == IDLE),
        .en_i     (wait_cyc),
        .timeout_o(timeout)
    );

    // Next state and all outputs from current state, live requests and ramstate.
    always_comb begin
        state_raw = state_q;
        wait_cyc  = 1'b0;
        ihit      = 1'b0;
        dhit      = 1'b0;
        imemload  = '0;
        dmemload  = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        case (state_q)
            IDLE: begin
                if (dreq) begin
                    state_raw = DACC;
                end else if (imemREN) begin
                    state_raw = IACC;
                end
            end
            DACC: begin
                ramaddr  = dmemaddr;
                ramstore = dmemstore;
                ramWEN   = dmemWEN;
                ramREN   = dmemREN & ~dmemWEN;
                if (!dreq) begin
                    state_raw = IDLE;
                end else if (ramstate == ACCESS) begin
                    dhit      = 1'b1;
                    dmemload  = ramload;
                    state_raw = IDLE;
                end else begin
                    wait_cyc = 1'b1;
                end
            end
            IACC: begin
                ramaddr = imemaddr;
                ramREN  = imemREN;
                if (!imemREN) begin
                    state_raw = IDLE;
                end else if (ramstate == ACCESS) begin
                    ihit      = 1'b1;
                    imemload  = ramload;
                    state_raw = IDLE;
                end else begin
                    wait_cyc = 1'b1;
                end
            end
            default: state_raw = IDLE;
        endcase
    end

    // Timeout overrides whatever the access wanted to do next.
    assign state_d  = timeout ? IDLE : state_raw;
    assign memerr_d = memerr_q | timeout;
    assign memerr   = memerr_q;

    // State and sticky error registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            memerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            memerr_q <= memerr_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Free-running hit and stall counters, wrapping at 2^32.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount     <= '0;
            dcount     <= '0;
            stallcount <= '0;
        end else begin
            icount     <= icount + word_t'(ihit);
            dcount     <= dcount + word_t'(dhit);
            stallcount <= stallcount + word_t'(wait_cyc);
        end
    end
`endif

endmodule
